alu_io_sequencer: RTL and testbench
===================================

Name: alu_io_sequencer

Overview:
- Front-end sequencer directly upstream and downstream of the one-hot ALU control unit.
- Accepts an operation request (op code plus operands A, Q, M) over a valid/ready handshake and pulses BEGIN.
- Drives each operand onto INBUS in the exact cycle the control unit sits in LOADA/LOADQ/LOADM.
- Captures OUTBUS during the PUSHA/PUSHQ strobes, then returns the result over a valid/ready response handshake. A watchdog flags hung operations.

Parameters:
- WIDTH, 8, operand/result width (matches the 4-step Radix-4 and 8-step SRT-2 counters).
- TIMEOUT, 64, maximum cycles spent in WAIT before aborting with an error.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_op  in  2  00 add, 01 sub, 10 mul, 11 div.
- req_a  in  WIDTH  operand A (add/sub first operand; div high dividend).
- req_q  in  WIDTH  operand Q (mul multiplier; div low dividend).
- req_m  in  WIDTH  operand M (second operand / multiplicand / divisor).
- BEGIN  out  1  one-cycle start pulse to the control unit.
- op_code  out  2  op code held stable from ISSUE through RESP.
- inbus  out  WIDTH  operand bus to the datapath.
- inbus_valid  out  1  inbus carries an operand this cycle.
- push_a  in  1  control unit is in PUSHA (OUTBUS = A).
- push_q  in  1  control unit is in PUSHQ (OUTBUS = Q).
- outbus  in  WIDTH  datapath result bus.
- busy  out  1  operation in flight (ISSUE, LOAD or WAIT).
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes result.
- rsp_a  out  WIDTH  captured A (sum/difference; mul high; div remainder).
- rsp_q  out  WIDTH  captured Q (mul low; div quotient; 0 for add/sub).
- rsp_err  out  1  timeout or protocol error.

Behaviour:
- Reset (reset=0, async):
  - State = IDLE.
  - req_ready=1; BEGIN, inbus_valid, busy, rsp_valid and rsp_err are 0.
  - inbus, op_code, rsp_a, rsp_q and all counters are 0.
  - Reset mid-operation aborts silently; no response is produced.
- FSM states: IDLE, ISSUE, LOAD, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid & req_ready, latch op/A/Q/M, clear rsp_a/rsp_q, go to ISSUE.
- ISSUE (exactly 1 cycle):
  - BEGIN=1, op_code = latched op.
  - Next state is LOAD with load index 0.
- LOAD (one cycle per operand, inbus_valid=1):
  - Load order: add/sub A then M (2 cycles); mul Q then M (2 cycles); div A, Q, then M (3 cycles).
  - After the last operand, go to WAIT. inbus=0 whenever inbus_valid=0.
- WAIT:
  - Watchdog counts cycles from 0.
  - push_a captures outbus into rsp_a; push_q captures outbus into rsp_q.
  - Expected push sequence: add/sub PUSHA; mul PUSHA then PUSHQ; div PUSHQ then PUSHA.
  - Completion: the cycle after the final expected push is captured, go to RESP with err=0.
- WAIT protocol errors (each goes to RESP with rsp_err=1):
  - push_a and push_q asserted in the same cycle: neither is captured.
  - A push out of the expected order.
  - Watchdog reaching TIMEOUT with the sequence incomplete.
- Pushes outside WAIT are ignored.
- RESP:
  - rsp_valid=1; rsp_a, rsp_q and rsp_err are stable while rsp_ready=0.
  - On rsp_ready, go to IDLE and clear rsp_valid and rsp_err. req_ready stays 0 in RESP, so there is no back-to-back accept in the same cycle.
- Latency:
  - BEGIN is 1 cycle after accept.
  - First operand on inbus is 2 cycles after accept.
  - rsp_valid rises 1 cycle after the final push.
- busy=1 in ISSUE, LOAD and WAIT.
- The watchdog resets on each entry to WAIT. It is WIDTH-independent and sized to hold TIMEOUT.

Test Plan:
- Reset mid-LOAD of a div (assert reset=0 during Q cycle) -> all outputs immediately 0; req_ready=1 after release; no rsp_valid.
- Add A=5, M=3; bench pulses push_a with outbus=8 in 3rd WAIT cycle -> BEGIN at cycle+1; inbus 5 then 3 with inbus_valid; rsp_valid next cycle with rsp_a=8, rsp_q=0, err=0.
- Mul Q=6, M=7; push_a outbus=0x00 then push_q outbus=0x2A -> inbus order 6,7; rsp_a=0x00, rsp_q=0x2A, err=0.
- Div A=0, Q=100, M=7; push_q outbus=14 then push_a outbus=2 -> inbus order 0,100,7; rsp_q=14, rsp_a=2. Hold rsp_ready=0 for 5 cycles -> outputs stable; accept -> IDLE.
- Div with push_a before push_q, or push_a and push_q in the same cycle -> RESP with rsp_err=1.
- Mul with no pushes -> rsp_err=1 exactly TIMEOUT (64) cycles after WAIT entry; rsp_a=rsp_q=0.

Source files
------------

// File: rtl/alu_io_sequencer.sv
// Request/response front end for the one-hot ALU control unit: issues BEGIN,
// streams operands onto INBUS and collects results from the PUSHA/PUSHQ strobes.
module alu_io_sequencer #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_q,
    input  logic [WIDTH-1:0] req_m,
    output logic             BEGIN,
    output logic [1:0]       op_code,
    output logic [WIDTH-1:0] inbus,
    output logic             inbus_valid,
    input  logic             push_a,
    input  logic             push_q,
    input  logic [WIDTH-1:0] outbus,
    output logic             busy,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_a,
    output logic [WIDTH-1:0] rsp_q,
    output logic             rsp_err
);

    localparam int              WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_LOAD, S_WAIT, S_RESP} state_e;
    typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01,
                              OP_MUL = 2'b10, OP_DIV = 2'b11} op_e;

    state_e           state_q;
    op_e              op_q;
    logic [WIDTH-1:0] a_q, q_q, m_q;
    logic [1:0]       load_idx_q;
    logic [1:0]       push_cnt_q;
    logic [WD_W-1:0]  wd_q;
    logic             req_ready_q, begin_q, inbus_valid_q, busy_q, rsp_valid_q, rsp_err_q;
    logic [WIDTH-1:0] inbus_q, rsp_a_q, rsp_q_q;

    logic             load_last;
    logic [WIDTH-1:0] next_operand;
    logic             exp_a, exp_q, final_push;
    logic             push_one, push_err, seq_done, wd_expired;

    // Operand streaming order: add/sub A,M; mul Q,M; div A,Q,M.
    function automatic logic [WIDTH-1:0] operand_sel(input op_e op, input logic [1:0] idx,
                                                     input logic [WIDTH-1:0] a,
                                                     input logic [WIDTH-1:0] q,
                                                     input logic [WIDTH-1:0] m);
        case (op)
            OP_DIV:  return (idx == 2'd0) ? a : (idx == 2'd1) ? q : m;
            OP_MUL:  return (idx == 2'd0) ? q : m;
            default: return (idx == 2'd0) ? a : m;
        endcase
    endfunction

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        load_last    = (op_q == OP_DIV) ? (load_idx_q == 2'd2) : (load_idx_q == 2'd1);
        next_operand = operand_sel(op_q, load_idx_q + 2'd1, a_q, q_q, m_q);
        exp_a        = 1'b0;
        exp_q        = 1'b0;
        final_push   = 1'b0;
        case (op_q)
            OP_MUL: begin
                exp_a      = (push_cnt_q == 2'd0);
                exp_q      = (push_cnt_q == 2'd1);
                final_push = (push_cnt_q == 2'd1);
            end
            OP_DIV: begin
                exp_q      = (push_cnt_q == 2'd0);
                exp_a      = (push_cnt_q == 2'd1);
                final_push = (push_cnt_q == 2'd1);
            end
            default: begin
                exp_a      = (push_cnt_q == 2'd0);
                final_push = 1'b1;
            end
        endcase
        push_one   = push_a ^ push_q;
        push_err   = (push_a & push_q) | (push_a & ~exp_a) | (push_q & ~exp_q);
        seq_done   = push_one & ~push_err & final_push;
        wd_expired = (wd_q == WD_LAST);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            op_q          <= OP_ADD;
            a_q           <= '0;
            q_q           <= '0;
            m_q           <= '0;
            load_idx_q    <= '0;
            push_cnt_q    <= '0;
            wd_q          <= '0;
            req_ready_q   <= 1'b1;
            begin_q       <= 1'b0;
            inbus_valid_q <= 1'b0;
            inbus_q       <= '0;
            busy_q        <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_a_q       <= '0;
            rsp_q_q       <= '0;
        end else begin
            begin_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q        <= op_e'(req_op);
                        a_q         <= req_a;
                        q_q         <= req_q;
                        m_q         <= req_m;
                        rsp_a_q     <= '0;
                        rsp_q_q     <= '0;
                        req_ready_q <= 1'b0;
                        begin_q     <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    load_idx_q    <= 2'd0;
                    inbus_q       <= operand_sel(op_q, 2'd0, a_q, q_q, m_q);
                    inbus_valid_q <= 1'b1;
                    state_q       <= S_LOAD;
                end
                S_LOAD: begin
                    if (load_last) begin
                        inbus_q       <= '0;
                        inbus_valid_q <= 1'b0;
                        wd_q          <= '0;
                        push_cnt_q    <= '0;
                        state_q       <= S_WAIT;
                    end else begin
                        load_idx_q <= load_idx_q + 2'd1;
                        inbus_q    <= next_operand;
                    end
                end
                S_WAIT: begin
                    wd_q <= wd_q + WD_W'(1);
                    // A lone push is always captured, even out of order; a double push is not.
                    if (push_one) begin
                        if (push_a) rsp_a_q <= outbus;
                        else        rsp_q_q <= outbus;
                        push_cnt_q <= push_cnt_q + 2'd1;
                    end
                    if (push_err || seq_done || wd_expired) begin
                        busy_q      <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= ~seq_done;
                        state_q     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign BEGIN       = begin_q;
    assign op_code     = op_q;
    assign inbus       = inbus_q;
    assign inbus_valid = inbus_valid_q;
    assign busy        = busy_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_a       = rsp_a_q;
    assign rsp_q       = rsp_q_q;
    assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_alu_io_sequencer.sv
// Randomized bench for alu_io_sequencer: a push-schedule reference model predicts
// operand order, response latency, captured values and the error flag.
module tb_alu_io_sequencer;

    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 64;
    localparam logic [1:0] OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_DIV = 2'b11;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_valid, req_ready;
    logic [1:0]       req_op;
    logic [WIDTH-1:0] req_a, req_q, req_m;
    logic             dut_begin;
    logic [1:0]       op_code;
    logic [WIDTH-1:0] inbus;
    logic             inbus_valid;
    logic             push_a, push_q;
    logic [WIDTH-1:0] outbus;
    logic             busy, rsp_valid, rsp_ready, rsp_err;
    logic [WIDTH-1:0] rsp_a, rsp_q;

    alu_io_sequencer #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_q      (req_q),
        .req_m      (req_m),
        .BEGIN      (dut_begin),
        .op_code    (op_code),
        .inbus      (inbus),
        .inbus_valid(inbus_valid),
        .push_a     (push_a),
        .push_q     (push_q),
        .outbus     (outbus),
        .busy       (busy),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_a      (rsp_a),
        .rsp_q      (rsp_q),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int         cyc;
        bit         pa;
        bit         pq;
        logic [7:0] val;
    } push_t;

    push_t pushes[$];

    task automatic add_push(input int cyc, input bit pa, input bit pq, input logic [7:0] val);
        push_t p;
        p.cyc = cyc;
        p.pa  = pa;
        p.pq  = pq;
        p.val = val;
        pushes.push_back(p);
    endtask

    // Walks the push schedule against the op's expected strobe order.
    task automatic model(input logic [1:0] op, output int end_cyc, output bit err,
                         output logic [7:0] ea, output logic [7:0] eq);
        string order;
        int    idx;
        order   = (op == OP_MUL) ? "AQ" : (op == OP_DIV) ? "QA" : "A";
        idx     = 0;
        ea      = 8'h00;
        eq      = 8'h00;
        err     = 1'b1;
        end_cyc = TIMEOUT - 1;
        foreach (pushes[i]) begin
            byte want;
            if (pushes[i].cyc > TIMEOUT - 1) return;
            if (pushes[i].pa && pushes[i].pq) begin
                end_cyc = pushes[i].cyc;
                return;
            end
            if (pushes[i].pa) ea = pushes[i].val;
            if (pushes[i].pq) eq = pushes[i].val;
            want = order[idx];
            if ((pushes[i].pa && want != "A") || (pushes[i].pq && want != "Q")) begin
                end_cyc = pushes[i].cyc;
                return;
            end
            idx++;
            if (idx == order.len()) begin
                end_cyc = pushes[i].cyc;
                err     = 1'b0;
                return;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic noise_push();
        push_a = 1'($urandom);
        push_q = 1'($urandom);
        outbus = 8'($urandom);
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [7:0] a,
                          input logic [7:0] q, input logic [7:0] m, input int hold);
        logic [7:0] ops[$];
        int         end_cyc;
        bit         err;
        logic [7:0] ea, eq;
        int         c;
        model(op, end_cyc, err, ea, eq);
        case (op)
            OP_DIV:  ops = '{a, q, m};
            OP_MUL:  ops = '{q, m};
            default: ops = '{a, m};
        endcase
        check({tag, " req_ready idle"}, req_ready, 1);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_q     = q;
        req_m     = m;
        tick();
        req_valid = 1'b0;
        req_a     = 8'($urandom);
        req_q     = 8'($urandom);
        req_m     = 8'($urandom);
        check({tag, " BEGIN"}, dut_begin, 1);
        check({tag, " op_code"}, op_code, op);
        check({tag, " busy issue"}, busy, 1);
        check({tag, " req_ready issue"}, req_ready, 0);
        check({tag, " inbus_valid issue"}, inbus_valid, 0);
        noise_push();
        tick();
        foreach (ops[i]) begin
            check($sformatf("%s inbus_valid[%0d]", tag, i), inbus_valid, 1);
            check($sformatf("%s inbus[%0d]", tag, i), inbus, ops[i]);
            check($sformatf("%s BEGIN low[%0d]", tag, i), dut_begin, 0);
            noise_push();
            tick();
        end
        check({tag, " inbus_valid wait"}, inbus_valid, 0);
        check({tag, " inbus wait"}, inbus, 0);
        check({tag, " busy wait"}, busy, 1);
        c = 0;
        while (!rsp_valid && c < TIMEOUT + 10) begin
            push_a = 1'b0;
            push_q = 1'b0;
            outbus = 8'($urandom);
            foreach (pushes[i]) begin
                if (pushes[i].cyc == c) begin
                    push_a = pushes[i].pa;
                    push_q = pushes[i].pq;
                    outbus = pushes[i].val;
                end
            end
            tick();
            c++;
        end
        push_a = 1'b0;
        push_q = 1'b0;
        check({tag, " rsp latency"}, c, end_cyc + 1);
        check({tag, " rsp_valid"}, rsp_valid, 1);
        check({tag, " rsp_a"}, rsp_a, ea);
        check({tag, " rsp_q"}, rsp_q, eq);
        check({tag, " rsp_err"}, rsp_err, err);
        check({tag, " busy resp"}, busy, 0);
        check({tag, " req_ready resp"}, req_ready, 0);
        check({tag, " op_code resp"}, op_code, op);
        for (int h = 0; h < hold; h++) begin
            rsp_ready = 1'b0;
            noise_push();
            tick();
            check($sformatf("%s hold rsp_valid[%0d]", tag, h), rsp_valid, 1);
            check($sformatf("%s hold rsp_a[%0d]", tag, h), rsp_a, ea);
            check($sformatf("%s hold rsp_q[%0d]", tag, h), rsp_q, eq);
            check($sformatf("%s hold rsp_err[%0d]", tag, h), rsp_err, err);
        end
        push_a    = 1'b0;
        push_q    = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({tag, " rsp_valid done"}, rsp_valid, 0);
        check({tag, " rsp_err done"}, rsp_err, 0);
        check({tag, " req_ready done"}, req_ready, 1);
        check({tag, " busy done"}, busy, 0);
    endtask

    task automatic reset_mid_div();
        req_valid = 1'b1;
        req_op    = OP_DIV;
        req_a     = 8'h11;
        req_q     = 8'h22;
        req_m     = 8'h33;
        tick();
        req_valid = 1'b0;
        tick();
        check("rst_mid inbus A", inbus, 8'h11);
        tick();
        check("rst_mid inbus Q", inbus, 8'h22);
        reset = 1'b0;
        #1;
        check("rst_mid inbus", inbus, 0);
        check("rst_mid inbus_valid", inbus_valid, 0);
        check("rst_mid BEGIN", dut_begin, 0);
        check("rst_mid busy", busy, 0);
        check("rst_mid op_code", op_code, 0);
        check("rst_mid rsp_valid", rsp_valid, 0);
        check("rst_mid req_ready", req_ready, 1);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("rst_mid post rsp_valid[%0d]", i), rsp_valid, 0);
            check($sformatf("rst_mid post req_ready[%0d]", i), req_ready, 1);
        end
    endtask

    task automatic random_op(input int it);
        logic [1:0] op;
        int         sc, c0;
        bit         first_a;
        op      = 2'($urandom_range(0, 3));
        sc      = $urandom_range(0, 4);
        first_a = (op != OP_DIV);
        c0      = $urandom_range(0, 6);
        pushes.delete();
        case (sc)
            0, 1: begin
                add_push(c0, first_a, !first_a, 8'($urandom));
                if (op[1]) add_push(c0 + $urandom_range(1, 6), !first_a, first_a, 8'($urandom));
            end
            2: begin
                add_push(c0, !first_a, first_a, 8'($urandom));
                add_push(c0 + $urandom_range(1, 6), first_a, !first_a, 8'($urandom));
            end
            3: add_push(c0, 1'b1, 1'b1, 8'($urandom));
            default: if (op[1] && $urandom_range(0, 1) == 1) add_push(c0, first_a, !first_a, 8'($urandom));
        endcase
        run_op($sformatf("rnd%0d", it), op, 8'($urandom), 8'($urandom), 8'($urandom),
               $urandom_range(0, 4));
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_a     = '0;
        req_q     = '0;
        req_m     = '0;
        push_a    = 1'b0;
        push_q    = 1'b0;
        outbus    = '0;
        rsp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset req_ready", req_ready, 1);
        check("reset BEGIN", dut_begin, 0);
        check("reset busy", busy, 0);
        check("reset rsp_valid", rsp_valid, 0);
        check("reset inbus_valid", inbus_valid, 0);
        check("reset inbus", inbus, 0);
        check("reset op_code", op_code, 0);
        check("reset rsp_a", rsp_a, 0);
        check("reset rsp_q", rsp_q, 0);
        check("reset rsp_err", rsp_err, 0);
        reset = 1'b1;
        @(negedge clk);

        reset_mid_div();

        pushes.delete();
        add_push(2, 1'b1, 1'b0, 8'd8);
        run_op("add_5_3", OP_ADD, 8'd5, 8'd0, 8'd3, 0);

        pushes.delete();
        add_push(1, 1'b1, 1'b0, 8'h00);
        add_push(3, 1'b0, 1'b1, 8'h2A);
        run_op("mul_6_7", OP_MUL, 8'd0, 8'd6, 8'd7, 1);

        pushes.delete();
        add_push(1, 1'b0, 1'b1, 8'd14);
        add_push(2, 1'b1, 1'b0, 8'd2);
        run_op("div_100_7", OP_DIV, 8'd0, 8'd100, 8'd7, 5);

        pushes.delete();
        add_push(1, 1'b1, 1'b0, 8'h5A);
        add_push(2, 1'b0, 1'b1, 8'h09);
        run_op("div_bad_order", OP_DIV, 8'd1, 8'd2, 8'd3, 0);

        pushes.delete();
        add_push(2, 1'b1, 1'b1, 8'h33);
        run_op("div_both", OP_DIV, 8'd4, 8'd5, 8'd6, 0);

        pushes.delete();
        add_push(0, 1'b0, 1'b1, 8'h77);
        run_op("sub_push_q", OP_SUB, 8'd9, 8'd0, 8'd4, 0);

        pushes.delete();
        run_op("mul_timeout", OP_MUL, 8'd0, 8'd6, 8'd7, 2);

        pushes.delete();
        add_push(TIMEOUT - 1, 1'b1, 1'b0, 8'hC3);
        run_op("add_last_cycle", OP_ADD, 8'd1, 8'd0, 8'd2, 0);

        for (int it = 0; it < 40; it++) random_op(it);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
